ms_display_scan: RTL
====================

// Module: ms_display_scan
// PURPOSE
//   Time-multiplexed 7-segment driver for the 3-digit BCD millisecond count (000-999) of the digital clock.
//   Consumes the MIL001/MIL010/MIL100 digits from the millisecond counter and drives one shared segment bus
//   plus per-digit enables. Captures all digits once per frame so a count rollover mid-frame never tears.
//   Also blanks leading zeros and flags illegal BCD codes.
// PARAMETERS
//   SCAN_DIV        4  clk cycles per digit slot; legal range > BLANK_CYC
//   BLANK_CYC       1  leading cycles of each slot with digit_en forced to 0 (anti-ghosting)
//   SEG_ACTIVE_LOW  0  1 = invert seg at output (common-anode display)
//   DIG_ACTIVE_LOW  0  1 = invert digit_en at output
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   MIL001      in   4  BCD ones digit
//   MIL010      in   4  BCD tens digit
//   MIL100      in   4  BCD hundreds digit
//   hold        in   1  1 = freeze the displayed snapshot (no reload at frame start)
//   seg         out  7  {g,f,e,d,c,b,a}, registered
//   digit_en    out  3  one-hot {hundreds,tens,ones}, registered
//   frame_done  out  1  1-cycle pulse in the last cycle of the hundreds slot
//   bcd_err     out  1  sticky: a digit > 9 was captured
// BEHAVIOUR
//   - Reset: state IDLE, div=0, snapshot=000.
//     seg=0000000, digit_en=000, frame_done=0, bcd_err=0 (before polarity inversion).
//     A mid-operation rst aborts the frame on the next edge with the same values.
//   - FSM: IDLE -> D0 (ones) -> D1 (tens) -> D2 (hundreds) -> D0 ...
//     IDLE lasts only while rst=1; first edge with rst=0 enters D0.
//   - Slot timing: div counts 0..SCAN_DIV-1 in each slot; the state advances when div==SCAN_DIV-1.
//     Frame period = 3*SCAN_DIV cycles.
//   - Snapshot: on every edge entering D0 with hold=0, all three inputs load into the snapshot.
//     hold=1 at that edge keeps the old snapshot. Inputs are never sampled at any other time.
//   - seg/digit_en are registered and change on the same edge as the state.
//     The value entering D0 is decoded from the inputs being captured: zero extra latency.
//   - digit_en = 000 while div < BLANK_CYC, otherwise the one-hot bit for the slot.
//     seg holds the slot pattern for the whole slot.
//   - Decode: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//             5=1101101 6=1111101 7=0000111 8=1111111 9=1101111.
//     Any code > 9 decodes to dash 1000000.
//   - Leading-zero blanking, evaluated on the snapshot:
//     hundreds blank if snap100==0; tens blank if snap100==0 and snap010==0; ones never blank.
//     Blank means seg=0000000; digit_en is still asserted.
//     An illegal code is non-zero and is never blanked.
//   - bcd_err sets on the capture edge if any captured digit > 9, and stays set until rst.
//   - frame_done = 1 exactly when state==D2 and div==SCAN_DIV-1.
//   - Polarity parameters invert only the final output flops. Internal logic is active-high.
// STRUCTURE
//   - Package ms_display_pkg holds:
//     state enum {IDLE,D0,D1,D2}, SEG_0..SEG_9, SEG_DASH, SEG_BLANK,
//     the one-hot constants DIG_ONES/DIG_TENS/DIG_HUNDS.
//   - Sub-module bcd_to_seg7 (combinational: 4-bit BCD + blank -> 7-bit pattern), single instance.
//     It sits behind the slot mux.
// TESTING (SCAN_DIV=4, BLANK_CYC=1, active-high outputs)
//   1. rst=1 for 3 cycles -> seg=0, digit_en=0, frame_done=0, bcd_err=0.
//      First edge after release: digit_en=000, seg=ones pattern.
//   2. Inputs 1/2/3 (hundreds/tens/ones), static -> per 12-cycle frame:
//      ones slot: cycle 1 digit_en=000, cycles 2-4 digit_en=001, seg=1001111;
//      tens slot: digit_en=010, seg=1011011; hundreds slot: digit_en=100, seg=0000110;
//      frame_done high on cycle 12 only.
//   3. Inputs 0/0/7 -> hundreds and tens slots seg=0000000, ones slot seg=0000111.
//      Inputs 0/0/0 -> ones slot seg=0111111.
//   4. Change inputs 099 -> 100 in the middle of the tens slot
//      -> remainder of the frame shows 9,9,(blank); the next frame shows 0,0,1.
//   5. Hold hold=1 across a frame boundary while inputs change -> displayed digits are unchanged.
//      Release -> new value shown from the following frame start.
//   6. MIL010=4'hC -> tens slot seg=1000000, bcd_err=1, and it stays 1 after valid inputs return.
//      Cleared only by rst.

Source files
------------

// File: rtl/ms_display_pkg.sv
// Shared types and constants for the millisecond display scanner.
package ms_display_pkg;

  typedef enum logic [1:0] {IDLE, D0, D1, D2} state_t;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } snap_t;

  // Segment patterns, {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [2:0] DIG_NONE  = 3'b000;
  localparam logic [2:0] DIG_ONES  = 3'b001;
  localparam logic [2:0] DIG_TENS  = 3'b010;
  localparam logic [2:0] DIG_HUNDS = 3'b100;

  function automatic logic bcd_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder with blanking; illegal codes show a dash.
module bcd_to_seg7
  import ms_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/ms_display_scan.sv
// Time-multiplexed 3-digit 7-segment scanner for the millisecond count.
// Snapshot is taken once per frame so a mid-frame count change never tears the display.
module ms_display_scan
  import ms_display_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int BLANK_CYC      = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] MIL001,
  input  logic [3:0] MIL010,
  input  logic [3:0] MIL100,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [2:0] digit_en,
  output logic       frame_done,
  output logic       bcd_err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK_CYC);
  localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0] DIG_XOR = (DIG_ACTIVE_LOW != 0) ? 3'h7 : 3'h0;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  snap_t            snap, snap_n;
  logic             err, err_n;
  logic             enter_d0, load;
  logic [3:0]       dsel;
  logic             bsel;
  logic [6:0]       seg_d;
  logic [2:0]       dig_d;
  logic             fd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      snap       <= '0;
      err        <= 1'b0;
      seg        <= SEG_BLANK ^ SEG_XOR;
      digit_en   <= DIG_NONE ^ DIG_XOR;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      snap       <= snap_n;
      err        <= err_n;
      seg        <= seg_d ^ SEG_XOR;
      digit_en   <= dig_d ^ DIG_XOR;
      frame_done <= fd_d;
    end
  end

  assign bcd_err = err;

  always_comb begin
    state_n  = state;
    div_n    = div + 1'b1;
    enter_d0 = 1'b0;
    if (state == IDLE) begin
      state_n  = D0;
      div_n    = '0;
      enter_d0 = 1'b1;
    end else if (div == DIV_LAST) begin
      div_n = '0;
      case (state)
        D0:      state_n = D1;
        D1:      state_n = D2;
        default: begin
          state_n  = D0;
          enter_d0 = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the next-state view so the captured value shows with no extra latency.
  always_comb begin
    load   = enter_d0 & ~hold;
    snap_n = load ? snap_t'{hund: MIL100, tens: MIL010, ones: MIL001} : snap;
    err_n  = err | (load & (bcd_bad(MIL100) | bcd_bad(MIL010) | bcd_bad(MIL001)));
    dsel   = 4'd0;
    bsel   = 1'b1;
    dig_d  = DIG_NONE;
    case (state_n)
      D0: begin
        dsel  = snap_n.ones;
        bsel  = 1'b0;
        dig_d = DIG_ONES;
      end
      D1: begin
        dsel  = snap_n.tens;
        bsel  = (snap_n.hund == 4'd0) && (snap_n.tens == 4'd0);
        dig_d = DIG_TENS;
      end
      D2: begin
        dsel  = snap_n.hund;
        bsel  = (snap_n.hund == 4'd0);
        dig_d = DIG_HUNDS;
      end
      default: ;
    endcase
    if (div_n < BLANK_V) dig_d = DIG_NONE;
    fd_d = (state_n == D2) && (div_n == DIV_LAST);
  end

  bcd_to_seg7 u_dec (
    .bcd   (dsel),
    .blank (bsel),
    .seg   (seg_d)
  );

endmodule
